// File: rtl/cpu_fetch_decode.sv
// Byte-serial fetch/decode stage for the MCS8 CPU: assembles 1/2/3-byte 8008
// instructions, classifies them and queues them in a fall-through FIFO.
module cpu_fetch_decode #(
   parameter int DEPTH  = 2,
   parameter int ADDR_W = 14
) (
   input  logic              CLK_I,
   input  logic              RSTN_I,
   input  logic [7:0]        BYTE_I,
   input  logic              BYTE_VLD_I,
   output logic              BYTE_RDY_O,
   input  logic              FLUSH_I,
   input  logic              RESUME_I,
   output logic              INS_VLD_O,
   input  logic              INS_RDY_I,
   output logic [7:0]        INS_OP_O,
   output logic [7:0]        INS_B2_O,
   output logic [ADDR_W-1:0] INS_ADDR_O,
   output logic [1:0]        INS_LEN_O,
   output logic [10:0]       INS_CLASS_O,
   output logic              HALT_O
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   typedef enum logic [1:0] {S_OP, S_B2, S_B3, S_HALT} state_t;

   function automatic logic [1:0] f_len(input logic [7:0] op);
      if (op[7:6] == 2'b00 && (op[2:0] == 3'b110 || op[2:0] == 3'b100)) return 2'd2;
      else if (op[7:6] == 2'b01 && op[0] == 1'b0)                         return 2'd3;
      else                                                                return 2'd1;
   endfunction

   function automatic logic [10:0] f_class(input logic [7:0] op);
      logic [10:0] c;
      c = '0;
      if (op == 8'h00 || op == 8'h01 || op == 8'hFF)                          c[10] = 1'b1;
      else if (op[7:6] == 2'b11 || (op[7:6] == 2'b00 && op[2:0] == 3'b110))   c[0]  = 1'b1;
      else if (op[7:6] == 2'b10 || (op[7:6] == 2'b00 && op[2:0] == 3'b100))   c[1]  = 1'b1;
      else if (op[7:6] == 2'b01 && op[1:0] == 2'b00)                          c[2]  = 1'b1;
      else if (op[7:6] == 2'b01 && op[1:0] == 2'b10)                          c[3]  = 1'b1;
      else if (op[7:6] == 2'b00 && op[1:0] == 2'b11)                          c[4]  = 1'b1;
      else if (op[7:6] == 2'b00 && op[2:0] == 3'b101)                         c[5]  = 1'b1;
      else if (op[7:4] == 4'b0100 && op[0])                                   c[6]  = 1'b1;
      else if (op[7:6] == 2'b01 && op[0])                                     c[7]  = 1'b1;
      else if (op[7:6] == 2'b00 && op[2:1] == 2'b00)                          c[8]  = 1'b1;
      else                                                                    c[9]  = 1'b1;
      return c;
   endfunction

   state_t            r_state;
   logic [7:0]        r_op;
   logic [7:0]        r_b2;
   logic [1:0]        r_len;
   logic              r_halt;
   logic [PTR_W-1:0]  r_wr;
   logic [PTR_W-1:0]  r_rd;
   logic [CNT_W-1:0]  r_count;

   logic [7:0]        r_mem_op   [DEPTH];
   logic [7:0]        r_mem_b2   [DEPTH];
   logic [ADDR_W-1:0] r_mem_addr [DEPTH];
   logic [1:0]        r_mem_len  [DEPTH];
   logic [10:0]       r_mem_cls  [DEPTH];

   logic              w_byte_rdy;
   logic              w_xfer;
   logic              w_pop;
   logic              w_push;
   logic [7:0]        w_op;
   logic [7:0]        w_b2;
   logic [ADDR_W-1:0] w_addr;
   logic [1:0]        w_len;
   logic [10:0]       w_class;
   logic [1:0]        w_byte_len;

   assign w_byte_rdy = RSTN_I & (r_count < FULL) & ~r_halt & ~FLUSH_I;
   assign w_xfer     = BYTE_VLD_I & w_byte_rdy;
   assign w_pop      = (r_count != '0) & INS_RDY_I & ~FLUSH_I;
   assign w_byte_len = f_len(BYTE_I);
   assign w_class    = f_class(w_op);

   // Assemble the FIFO entry on the cycle the final byte of an instruction arrives.
   always_comb begin
      w_push = 1'b0;
      w_op   = r_op;
      w_b2   = r_b2;
      w_addr = '0;
      w_len  = r_len;
      case (r_state)
         S_OP: begin
            w_op = BYTE_I;
            w_b2 = '0;
            if (w_xfer && w_byte_len == 2'd1) begin
               w_push = 1'b1;
               w_len  = 2'd1;
            end
         end
         S_B2: begin
            w_b2 = BYTE_I;
            if (w_xfer && r_len == 2'd2) w_push = 1'b1;
         end
         S_B3: begin
            w_addr = {BYTE_I[ADDR_W-9:0], r_b2};
            if (w_xfer) w_push = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK_I or negedge RSTN_I) begin
      if (!RSTN_I) begin
         r_state <= S_OP;
         r_op    <= '0;
         r_b2    <= '0;
         r_len   <= '0;
         r_halt  <= 1'b0;
      end else if (FLUSH_I) begin
         r_state <= S_OP;
         r_halt  <= 1'b0;
      end else begin
         case (r_state)
            S_OP: if (w_xfer) begin
               r_op  <= BYTE_I;
               r_len <= w_byte_len;
               if (w_byte_len != 2'd1) begin
                  r_state <= S_B2;
               end else if (w_class[10]) begin
                  r_state <= S_HALT;
                  r_halt  <= 1'b1;
               end
            end
            S_B2: if (w_xfer) begin
               r_b2    <= BYTE_I;
               r_state <= (r_len == 2'd2) ? S_OP : S_B3;
            end
            S_B3: if (w_xfer) r_state <= S_OP;
            S_HALT: if (RESUME_I) begin
               r_state <= S_OP;
               r_halt  <= 1'b0;
            end
            default: r_state <= S_OP;
         endcase
      end
   end

   always_ff @(posedge CLK_I or negedge RSTN_I) begin
      if (!RSTN_I) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else if (FLUSH_I) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + PTR_W'(1);
         if (w_pop)  r_rd <= r_rd + PTR_W'(1);
         if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
         else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
      end
   end

   // Storage needs no reset: every field is masked while the FIFO is empty.
   always_ff @(posedge CLK_I) begin
      if (w_push) begin
         r_mem_op[r_wr]   <= w_op;
         r_mem_b2[r_wr]   <= w_b2;
         r_mem_addr[r_wr] <= w_addr;
         r_mem_len[r_wr]  <= w_len;
         r_mem_cls[r_wr]  <= w_class;
      end
   end

   assign BYTE_RDY_O  = w_byte_rdy;
   assign HALT_O      = r_halt;
   assign INS_VLD_O   = (r_count != '0);
   assign INS_OP_O    = INS_VLD_O ? r_mem_op[r_rd]   : '0;
   assign INS_B2_O    = INS_VLD_O ? r_mem_b2[r_rd]   : '0;
   assign INS_ADDR_O  = INS_VLD_O ? r_mem_addr[r_rd] : '0;
   assign INS_LEN_O   = INS_VLD_O ? r_mem_len[r_rd]  : '0;
   assign INS_CLASS_O = INS_VLD_O ? r_mem_cls[r_rd]  : '0;

endmodule

// File: tb/tb_cpu_fetch_decode.sv
// Self-checking bench for cpu_fetch_decode: directed scenarios plus random
// instruction streams scored against a queue-based instruction model.
module tb_cpu_fetch_decode;

   logic        clock = 1'b0;
   logic        rstN;
   logic [7:0]  byteI;
   logic        byteVld;
   logic        byteRdy;
   logic        flush;
   logic        resume;
   logic        insVld;
   logic        insRdy;
   logic [7:0]  insOp;
   logic [7:0]  insB2;
   logic [13:0] insAddr;
   logic [1:0]  insLen;
   logic [10:0] insCls;
   logic        halt;

   logic        byteRdy9;
   logic        insVld9;
   logic [7:0]  insOp9;
   logic [7:0]  insB29;
   logic [8:0]  insAddr9;
   logic [1:0]  insLen9;
   logic [10:0] insCls9;
   logic        halt9;

   typedef struct {
      logic [7:0]  op;
      logic [7:0]  b2;
      logic [13:0] a14;
      logic [8:0]  a9;
      logic [1:0]  len;
      logic [10:0] cls;
   } insT;

   insT expQ[$];
   int  partial[$];
   bit  modelHalt;
   bit  randRdy;
   int  checks;
   int  errors;
   int  popCount;
   int  popMark;
   int  rOp;
   int  rLen;
   bit  doFl;

   cpu_fetch_decode #(.DEPTH(2), .ADDR_W(14)) dut (
      .CLK_I(clock), .RSTN_I(rstN), .BYTE_I(byteI), .BYTE_VLD_I(byteVld),
      .BYTE_RDY_O(byteRdy), .FLUSH_I(flush), .RESUME_I(resume),
      .INS_VLD_O(insVld), .INS_RDY_I(insRdy), .INS_OP_O(insOp), .INS_B2_O(insB2),
      .INS_ADDR_O(insAddr), .INS_LEN_O(insLen), .INS_CLASS_O(insCls), .HALT_O(halt)
   );

   cpu_fetch_decode #(.DEPTH(2), .ADDR_W(9)) dut9 (
      .CLK_I(clock), .RSTN_I(rstN), .BYTE_I(byteI), .BYTE_VLD_I(byteVld),
      .BYTE_RDY_O(byteRdy9), .FLUSH_I(flush), .RESUME_I(resume),
      .INS_VLD_O(insVld9), .INS_RDY_I(insRdy), .INS_OP_O(insOp9), .INS_B2_O(insB29),
      .INS_ADDR_O(insAddr9), .INS_LEN_O(insLen9), .INS_CLASS_O(insCls9), .HALT_O(halt9)
   );

   always #5 clock = ~clock;

   function automatic int refLen(int op);
      int hi = op / 64;
      if (hi == 0 && (op % 8 == 6 || op % 8 == 4)) return 2;
      if (hi == 1 && (op % 4 == 0 || op % 4 == 2)) return 3;
      return 1;
   endfunction

   function automatic int refClass(int op);
      int hi = op / 64;
      int lo3 = op % 8;
      if (op == 0 || op == 1 || op == 255)                 return 10;
      if (hi == 3 || (hi == 0 && lo3 == 6))                return 0;
      if (hi == 2 || (hi == 0 && lo3 == 4))                return 1;
      if (hi == 1 && op % 4 == 0)                          return 2;
      if (hi == 1 && op % 4 == 2)                          return 3;
      if (hi == 0 && op % 4 == 3)                          return 4;
      if (hi == 0 && lo3 == 5)                             return 5;
      if (hi == 1 && (op / 16) % 4 == 0 && op % 2 == 1)    return 6;
      if (hi == 1 && op % 2 == 1)                          return 7;
      if (hi == 0 && (lo3 == 0 || lo3 == 1))               return 8;
      return 9;
   endfunction

   task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Feed one byte into the instruction model; completed instructions join the expected queue.
   task automatic modelByte(int b);
      insT e;
      int  l;
      int  full;
      partial.push_back(b);
      l = refLen(partial[0]);
      if (partial.size() == l) begin
         full  = (l == 3) ? partial[2] * 256 + partial[1] : 0;
         e.op  = 8'(partial[0]);
         e.b2  = (l > 1) ? 8'(partial[1]) : 8'h00;
         e.a14 = 14'(full % 16384);
         e.a9  = 9'(full % 512);
         e.len = 2'(l);
         e.cls = 11'(1) << refClass(partial[0]);
         if (refClass(partial[0]) == 10) modelHalt = 1'b1;
         expQ.push_back(e);
         partial.delete();
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      if (randRdy) insRdy = 1'($urandom_range(0, 1));
   endtask

   // Present one byte and hold it until it transfers; always entered just after a rising edge.
   task automatic applyStimulus(logic [7:0] b);
      bit ok = 1'b0;
      byteI   = b;
      byteVld = 1'b1;
      for (int n = 0; n < 300; n++) begin
         @(negedge clock);
         if (byteRdy) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      checkOutput("byte_accept", 32'(ok), 32'd1);
      if (ok) begin
         tick();
         modelByte(int'(b));
      end
      byteVld = 1'b0;
   endtask

   task automatic doFlush();
      flush   = 1'b1;
      byteVld = 1'b0;
      tick();
      flush = 1'b0;
      expQ.delete();
      partial.delete();
      modelHalt = 1'b0;
   endtask

   task automatic drain();
      insRdy = 1'b1;
      for (int n = 0; n < 60; n++) begin
         if (expQ.size() == 0) break;
         tick();
      end
      tick();
   endtask

   // Score every pop against the model, and check that an empty head reads as zero.
   always @(negedge clock) begin
      if (rstN) begin
         if (insVld && insRdy && !flush) begin : popChk
            insT e;
            popCount++;
            if (expQ.size() == 0) begin
               checkOutput("unexpected_pop", 32'(insVld), 32'd0);
            end else begin
               e = expQ.pop_front();
               checkOutput("pop_op",     32'(insOp),    32'(e.op));
               checkOutput("pop_b2",     32'(insB2),    32'(e.b2));
               checkOutput("pop_addr14", 32'(insAddr),  32'(e.a14));
               checkOutput("pop_addr9",  32'(insAddr9), 32'(e.a9));
               checkOutput("pop_op9",    32'(insOp9),   32'(e.op));
               checkOutput("pop_len",    32'(insLen),   32'(e.len));
               checkOutput("pop_class",  32'(insCls),   32'(e.cls));
            end
         end else if (!insVld) begin
            checkOutput("idle_fields_zero", 32'(|{insOp, insB2, insAddr, insLen, insCls}), 32'd0);
         end
      end
   end

   initial begin
      checks = 0; errors = 0; popCount = 0;
      rstN = 1'b0; byteI = 8'h06; byteVld = 1'b1;
      flush = 1'b0; resume = 1'b0; insRdy = 1'b0;
      randRdy = 1'b0; modelHalt = 1'b0;

      // Reset behaviour
      repeat (3) @(negedge clock);
      checkOutput("reset_rdy_low", 32'(byteRdy), 32'd0);
      @(posedge clock); #1;
      byteVld = 1'b0;
      rstN    = 1'b1;
      @(negedge clock);
      checkOutput("reset_vld",    32'(insVld),  32'd0);
      checkOutput("reset_halt",   32'(halt),    32'd0);
      checkOutput("reset_rdy",    32'(byteRdy), 32'd1);
      checkOutput("reset_fields", 32'(|{insOp, insB2, insAddr, insLen, insCls}), 32'd0);
      tick();
      insRdy = 1'b1;

      // MVI then a 1-byte load
      applyStimulus(8'h06);
      applyStimulus(8'h2A);
      applyStimulus(8'hC1);
      @(negedge clock);
      checkOutput("c1_latency_vld", 32'(insVld), 32'd1);
      checkOutput("c1_latency_op",  32'(insOp),  32'hC1);
      tick();
      drain();

      // 3-byte jump, address in both widths
      applyStimulus(8'h44);
      applyStimulus(8'h34);
      applyStimulus(8'h12);
      drain();

      // Back-pressure with a full FIFO
      insRdy = 1'b0;
      applyStimulus(8'h80);
      applyStimulus(8'h81);
      byteI = 8'h82; byteVld = 1'b1;
      @(negedge clock);
      checkOutput("full_rdy_low", 32'(byteRdy), 32'd0);
      checkOutput("full_head_op", 32'(insOp),   32'h80);
      tick();
      insRdy = 1'b1;
      tick();
      insRdy = 1'b0;
      @(negedge clock);
      checkOutput("rdy_after_pop", 32'(byteRdy), 32'd1);
      tick();
      byteVld = 1'b0;
      modelByte(8'h82);
      drain();

      // Halt and resume
      applyStimulus(8'hFF);
      checkOutput("hlt_halt", 32'(halt), 32'd1);
      byteI = 8'h07; byteVld = 1'b1;
      @(negedge clock);
      checkOutput("halt_rdy_low", 32'(byteRdy), 32'd0);
      tick();
      byteVld = 1'b0;
      resume  = 1'b1;
      tick();
      resume    = 1'b0;
      modelHalt = 1'b0;
      @(negedge clock);
      checkOutput("resume_halt_clear", 32'(halt),    32'd0);
      checkOutput("resume_rdy",        32'(byteRdy), 32'd1);
      tick();
      applyStimulus(8'h07);
      drain();

      // Flush mid-instruction discards the partial CALL
      applyStimulus(8'h46);
      applyStimulus(8'h00);
      flush = 1'b1;
      @(negedge clock);
      checkOutput("flush_rdy_low", 32'(byteRdy), 32'd0);
      tick();
      flush = 1'b0;
      expQ.delete();
      partial.delete();
      popMark = popCount;
      applyStimulus(8'h07);
      drain();
      checkOutput("flush_single_entry", 32'(popCount - popMark), 32'd1);

      // Flush with two queued entries and a pop attempt in the same cycle
      insRdy = 1'b0;
      applyStimulus(8'h80);
      applyStimulus(8'hC1);
      @(negedge clock);
      checkOutput("two_queued_vld", 32'(insVld),  32'd1);
      checkOutput("two_queued_rdy", 32'(byteRdy), 32'd0);
      tick();
      insRdy = 1'b1;
      doFlush();
      insRdy = 1'b0;
      @(negedge clock);
      checkOutput("flush_empty_vld", 32'(insVld),  32'd0);
      checkOutput("flush_empty_rdy", 32'(byteRdy), 32'd1);
      tick();

      // Random instruction stream with random consumer stalls and occasional flushes
      randRdy = 1'b1;
      for (int i = 0; i < 250; i++) begin
         rOp  = int'($urandom_range(0, 255));
         rLen = refLen(rOp);
         doFl = ($urandom_range(0, 19) == 0) && (rLen > 1);
         applyStimulus(8'(rOp));
         if (doFl) begin
            doFlush();
         end else begin
            for (int k = 1; k < rLen; k++) applyStimulus(8'($urandom_range(0, 255)));
            checkOutput("rand_halt", 32'(halt), 32'(modelHalt));
            if (modelHalt) begin
               repeat ($urandom_range(0, 3)) tick();
               resume = 1'b1;
               tick();
               resume    = 1'b0;
               modelHalt = 1'b0;
               checkOutput("rand_resume", 32'(halt), 32'd0);
            end
         end
      end
      randRdy = 1'b0;
      drain();
      @(negedge clock);
      checkOutput("final_model_empty", 32'(expQ.size()), 32'd0);
      checkOutput("final_fifo_empty",  32'(insVld),       32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
